route_arbiter: RTL and testbench
================================

# route_arbiter

Allocation and flow-control stage directly upstream of the router's output crossbar. It reads the head flits of the three first-word-fall-through input FIFOs (x, y, local) and computes each packet's output port by XY routing. It arbitrates round-robin per output and holds each grant for a whole wormhole packet. Per cycle it drives the 2-bit per-output select codes consumed by the crossbar and the FIFO pop strobes.

## Interface
- `MY_X`, default 0: this router's x coordinate (4 bits).
- `MY_Y`, default 0: this router's y coordinate (4 bits).
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `din_x` / `din_y` / `din_local` in 40: head flit of each input FIFO (FWFT); valid only when the matching `empty_*` is 0.
- `empty_x` / `empty_y` / `empty_local` in 1: input FIFO empty.
- `ready_x` / `ready_y` / `ready_local` in 1: the downstream receiver of that output can accept one flit. It must already include the crossbar's 1-cycle register.
- `control_x` / `control_y` / `control_local` out 2: crossbar select per output. Codes: 00 none, 01 from x, 10 from y, 11 from local.
- `pop_x` / `pop_y` / `pop_local` out 1: dequeue the head of that input FIFO at this clock edge.
- `drop_err` out 1: 1-cycle pulse when an orphan flit is discarded.

## Operation
- Flit format:
  - [39] head; [38] tail (head+tail = single-flit packet).
  - Head flits: [37:34] dest_x, [33:30] dest_y, [29:0] payload.
  - Body/tail flits: [37:0] payload.
- Route, evaluated on head flits only: dest_x≠MY_X → x; else dest_y≠MY_Y → y; else local. Same-port turnaround (x→x) is legal.
- Per-output FSM, registered:
  - IDLE → BUSY(owner) at the edge where that output's arbiter grants.
  - BUSY(owner) → IDLE at the edge where a tail flit from the owner is popped.
- Per-input lock, registered: `locked_in` and `out_port`, set and cleared together with the output FSM. An input owns at most one output.
- Request: an input requests at most one output. It requests when it is not empty, not locked, its head has [39]=1, and the routed output is IDLE.
- Arbitration:
  - Each output has a round-robin pointer with order x→y→local→x.
  - The winner is the first requester at or after the pointer.
  - On grant, the pointer moves to the position after the winner.
  - Pointer reset value: x.
- Transfer, combinational from registered state. For output o in BUSY(i): if empty_i=0 and ready_o=1, then control_o=code(i) and pop_i=1; otherwise control_o=00.
- While locked, the head bit of a flit is ignored and flits are forwarded until tail=1.
- Orphan flit: an input that is unlocked and non-empty with head bit 0. Pop it with no control asserted, and pulse drop_err in the same cycle.
- Reset values:
  - Outputs: control_*=00, pop_*=0, drop_err=0.
  - State: all FSMs IDLE, all locks clear, all pointers = x.
- Reset asserted mid-packet: all state clears asynchronously, and the partial packet is abandoned. Its remaining flits are later dropped as orphans.

## Timing
- Head visible at cycle 0 → grant registered at edge 0→1 → control/pop asserted in cycle 1.
- The crossbar captures the flit and the FIFO advances at edge 1→2. Head latency: 1 cycle of allocation.
- Body flits: 1 per cycle per output while not empty and ready, with no bubbles.
- Back-to-back packets on one output: the lock releases on the tail pop edge. The next head is granted at the following edge, so there is 1 idle cycle between packets.
- Simultaneous events:
  - A tail pop and a new grant for the same output in the same cycle cannot occur; the FSM is BUSY during the tail cycle.
  - Three outputs may each transfer in the same cycle from three different inputs.
- ready_o low: control_o=00 and pop_i=0. The grant is held with no timeout.

## Structure
- Package `router_pkg`:
  - Flit field positions: HEAD_BIT=39, TAIL_BIT=38, DX_MSB/LSB, DY_MSB/LSB.
  - Port code constants: PORT_NONE=2'b00, PORT_X=2'b01, PORT_Y=2'b10, PORT_LOCAL=2'b11.
  - Function `xy_route(dx, dy, my_x, my_y)` returning a port code.
- Sub-module `rr_arbiter3` (3 requests, grant one-hot, registered pointer, `advance` input), instantiated once per output.

## Test plan
- MY=(2,1); single-flit packet on x with dest (5,1) → control_x=01 and pop_x=1 exactly one cycle after the head is visible. FSM returns to IDLE.
- 4-flit packet on local with dest (2,3) → control_y=11 for 4 consecutive cycles, then control_y=00. Lock cleared after the tail.
- x, y, local heads all routed to local in the same cycle → grants in order x, y, local (one packet each). Pointer wraps back to x.
- ready_local held low for 3 cycles mid-packet → control_local=00 and pop=0 during the stall. The remaining flits then resume in order with none lost or duplicated.
- Body flit (head=0) at an unlocked input y → pop_y=1, all controls 00, drop_err=1 for one cycle.
- rst_n pulsed low during flit 2 of 4 → all outputs 0 immediately. The leftover body/tail flits are dropped with drop_err, and the next head is routed normally.

Source files
------------

// File: rtl/router_pkg.sv
// Shared flit layout, port codes and routing helpers for the router allocation stage.
package router_pkg;

  localparam int unsigned FLIT_W   = 40;
  localparam int unsigned HEAD_BIT = 39;
  localparam int unsigned TAIL_BIT = 38;
  localparam int unsigned DX_MSB   = 37;
  localparam int unsigned DX_LSB   = 34;
  localparam int unsigned DY_MSB   = 33;
  localparam int unsigned DY_LSB   = 30;

  localparam logic [1:0] PORT_NONE  = 2'b00;
  localparam logic [1:0] PORT_X     = 2'b01;
  localparam logic [1:0] PORT_Y     = 2'b10;
  localparam logic [1:0] PORT_LOCAL = 2'b11;

  typedef enum logic {StIdle, StBusy} out_state_e;

  // Dimension-ordered routing: resolve x first, then y, else eject locally.
  function automatic logic [1:0] xy_route(input logic [3:0] dx, input logic [3:0] dy,
                                          input logic [3:0] my_x, input logic [3:0] my_y);
    if (dx != my_x) return PORT_X;
    else if (dy != my_y) return PORT_Y;
    else return PORT_LOCAL;
  endfunction

  // Next index in the x -> y -> local -> x rotation.
  function automatic logic [1:0] rr_next(input logic [1:0] idx);
    return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
  endfunction

endpackage

// File: rtl/rr_arbiter3.sv
// Three-way round-robin arbiter; pointer moves past the winner when advance_i is set.
module rr_arbiter3
  import router_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [2:0] req_i,
  input  logic       advance_i,
  output logic [2:0] grant_o
);

  logic [1:0] ptr_q, ptr_d;
  logic [1:0] sel;
  logic       found;

  always_comb begin
    grant_o = '0;
    ptr_d   = ptr_q;
    found   = 1'b0;
    sel     = ptr_q;
    for (int k = 0; k < 3; k++) begin
      if (!found && req_i[sel]) begin
        grant_o[sel] = 1'b1;
        found        = 1'b1;
        ptr_d        = rr_next(sel);
      end
      sel = rr_next(sel);
    end
    if (!advance_i) ptr_d = ptr_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) ptr_q <= 2'd0;
    else         ptr_q <= ptr_d;
  end

endmodule

// File: rtl/route_arbiter.sv
// XY-routed, wormhole-locked round-robin allocator driving crossbar selects and FIFO pops.
module route_arbiter
  import router_pkg::*;
#(
  parameter logic [3:0] MY_X = 4'd0,
  parameter logic [3:0] MY_Y = 4'd0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [FLIT_W-1:0] din_x,
  input  logic [FLIT_W-1:0] din_y,
  input  logic [FLIT_W-1:0] din_local,
  input  logic              empty_x,
  input  logic              empty_y,
  input  logic              empty_local,
  input  logic              ready_x,
  input  logic              ready_y,
  input  logic              ready_local,
  output logic [1:0]        control_x,
  output logic [1:0]        control_y,
  output logic [1:0]        control_local,
  output logic              pop_x,
  output logic              pop_y,
  output logic              pop_local,
  output logic              drop_err
);

  // Index 0 = x, 1 = y, 2 = local, for both inputs and outputs.
  logic [FLIT_W-1:0] din [3];
  logic [2:0]        empty, ready;

  assign din[0] = din_x;
  assign din[1] = din_y;
  assign din[2] = din_local;
  assign empty  = {empty_local, empty_y, empty_x};
  assign ready  = {ready_local, ready_y, ready_x};

  out_state_e st_q [3], st_d [3];
  logic [1:0] owner_q [3], owner_d [3];
  logic [1:0] out_port_q [3], out_port_d [3];
  logic [2:0] locked_q, locked_d;

  logic [1:0] route [3];
  logic [1:0] dest;
  logic [2:0] req [3];
  logic [2:0] grant [3];
  logic [1:0] ctrl [3];
  logic [2:0] pop;
  logic [1:0] src;
  logic       drop;

  always_comb begin
    dest = 2'd0;
    for (int o = 0; o < 3; o++) req[o] = '0;
    for (int i = 0; i < 3; i++) begin
      route[i] = xy_route(din[i][DX_MSB:DX_LSB], din[i][DY_MSB:DY_LSB], MY_X, MY_Y);
      dest     = route[i] - 2'd1;
      if (!empty[i] && !locked_q[i] && din[i][HEAD_BIT]) begin
        for (int o = 0; o < 3; o++) begin
          if (dest == 2'(o) && st_q[o] == StIdle) req[o][i] = 1'b1;
        end
      end
    end
  end

  for (genvar g = 0; g < 3; g++) begin : gen_arb
    rr_arbiter3 u_arb (
      .clk_i     (clk),
      .rst_ni    (rst_n),
      .req_i     (req[g]),
      .advance_i (st_q[g] == StIdle),
      .grant_o   (grant[g])
    );
  end

  always_comb begin
    st_d       = st_q;
    owner_d    = owner_q;
    out_port_d = out_port_q;
    locked_d   = locked_q;
    ctrl       = '{default: PORT_NONE};
    pop        = '0;
    drop       = 1'b0;
    src        = 2'd0;
    for (int o = 0; o < 3; o++) begin
      if (st_q[o] == StIdle) begin
        for (int i = 0; i < 3; i++) begin
          if (grant[o][i]) begin
            st_d[o]       = StBusy;
            owner_d[o]    = 2'(i);
            locked_d[i]   = 1'b1;
            out_port_d[i] = 2'(o);
          end
        end
      end else begin
        src = owner_q[o];
        if (!empty[src] && ready[o]) begin
          ctrl[o]  = src + 2'd1;
          pop[src] = 1'b1;
          if (din[src][TAIL_BIT]) begin
            st_d[out_port_q[src]] = StIdle;
            locked_d[src]         = 1'b0;
          end
        end
      end
    end
    // Unlocked non-head flits belong to no packet: discard them.
    for (int i = 0; i < 3; i++) begin
      if (!locked_q[i] && !empty[i] && !din[i][HEAD_BIT]) begin
        pop[i] = 1'b1;
        drop   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 3; k++) begin
        st_q[k]       <= StIdle;
        owner_q[k]    <= 2'd0;
        out_port_q[k] <= 2'd0;
      end
      locked_q <= '0;
    end else begin
      st_q       <= st_d;
      owner_q    <= owner_d;
      out_port_q <= out_port_d;
      locked_q   <= locked_d;
    end
  end

  // Outputs are forced idle while reset is held.
  assign control_x     = rst_n ? ctrl[0] : PORT_NONE;
  assign control_y     = rst_n ? ctrl[1] : PORT_NONE;
  assign control_local = rst_n ? ctrl[2] : PORT_NONE;
  assign pop_x         = rst_n & pop[0];
  assign pop_y         = rst_n & pop[1];
  assign pop_local     = rst_n & pop[2];
  assign drop_err      = rst_n & drop;

  logic unused_payload;
  assign unused_payload = ^{din[0][29:0], din[1][29:0], din[2][29:0]};

endmodule

// File: tb/tb_route_arbiter.sv
// Scoreboard bench for route_arbiter at MY=(2,1) with behavioural FWFT input FIFOs.
module tb_route_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [39:0] din [3];
  logic [2:0]  empty, ready, pop;
  logic [1:0]  ctrl [3];
  logic        drop_err;

  always #5 clk = ~clk;

  route_arbiter #(.MY_X(4'd2), .MY_Y(4'd1)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .din_x         (din[0]),
    .din_y         (din[1]),
    .din_local     (din[2]),
    .empty_x       (empty[0]),
    .empty_y       (empty[1]),
    .empty_local   (empty[2]),
    .ready_x       (ready[0]),
    .ready_y       (ready[1]),
    .ready_local   (ready[2]),
    .control_x     (ctrl[0]),
    .control_y     (ctrl[1]),
    .control_local (ctrl[2]),
    .pop_x         (pop[0]),
    .pop_y         (pop[1]),
    .pop_local     (pop[2]),
    .drop_err      (drop_err)
  );

  logic [39:0] fq0[$], fq1[$], fq2[$];
  logic [39:0] eq0[$], eq1[$], eq2[$];
  logic [41:0] dq[$];
  int n_cmp = 0;
  int n_err = 0;

  logic [1:0]  s_ctrl [3];
  logic [39:0] s_din [3];
  logic [2:0]  s_pop;
  logic        s_drop;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [39:0] hflit(input logic [3:0] dx, input logic [3:0] dy,
                                        input logic tail, input logic [29:0] pl);
    return {1'b1, tail, dx, dy, pl};
  endfunction

  function automatic logic [39:0] bflit(input logic tail, input logic [37:0] pl);
    return {1'b0, tail, pl};
  endfunction

  task automatic upd();
    din[0] = (fq0.size() > 0) ? fq0[0] : 40'h0;
    din[1] = (fq1.size() > 0) ? fq1[0] : 40'h0;
    din[2] = (fq2.size() > 0) ? fq2[0] : 40'h0;
    empty  = {fq2.size() == 0, fq1.size() == 0, fq0.size() == 0};
  endtask

  task automatic push_in(input int p, input logic [39:0] f);
    case (p)
      0:       fq0.push_back(f);
      1:       fq1.push_back(f);
      default: fq2.push_back(f);
    endcase
    upd();
  endtask

  task automatic push_exp(input int o, input logic [39:0] f);
    case (o)
      0:       eq0.push_back(f);
      1:       eq1.push_back(f);
      default: eq2.push_back(f);
    endcase
  endtask

  task automatic pop_exp(input int o, output logic [39:0] f, output logic ok);
    f  = 40'h0;
    ok = 1'b0;
    case (o)
      0:       if (eq0.size() > 0) begin f = eq0.pop_front(); ok = 1'b1; end
      1:       if (eq1.size() > 0) begin f = eq1.pop_front(); ok = 1'b1; end
      default: if (eq2.size() > 0) begin f = eq2.pop_front(); ok = 1'b1; end
    endcase
  endtask

  function automatic int pending();
    return fq0.size() + fq1.size() + fq2.size() + eq0.size() + eq1.size() + eq2.size()
           + dq.size();
  endfunction

  // One cycle: sample at negedge, score transfers and drops, then apply pops after the edge.
  task automatic tick();
    logic [2:0]  srcd;
    logic [39:0] f;
    logic [41:0] fd;
    logic        ok;
    int          s;
    @(negedge clk);
    s_ctrl = ctrl;
    s_din  = din;
    s_pop  = pop;
    s_drop = drop_err;
    srcd   = '0;
    for (int o = 0; o < 3; o++) begin
      if (s_ctrl[o] != 2'b00) begin
        s       = int'(s_ctrl[o]) - 1;
        srcd[s] = 1'b1;
        check_eq("xfer_pop", s_pop[s], 1);
        pop_exp(o, f, ok);
        check_eq("xfer_expected", ok, 1);
        if (ok) check_eq("xfer_flit", s_din[s], f);
      end
    end
    check_eq("drop_err", s_drop, |(s_pop & ~srcd));
    for (int i = 0; i < 3; i++) begin
      if (s_pop[i] && !srcd[i]) begin
        ok = (dq.size() > 0);
        check_eq("drop_expected", ok, 1);
        fd = ok ? dq.pop_front() : 42'h0;
        if (ok) check_eq("drop_flit", {2'(i), s_din[i]}, fd);
      end
    end
    @(posedge clk);
    #1;
    if (s_pop[0] && fq0.size() > 0) void'(fq0.pop_front());
    if (s_pop[1] && fq1.size() > 0) void'(fq1.pop_front());
    if (s_pop[2] && fq2.size() > 0) void'(fq2.pop_front());
    upd();
  endtask

  task automatic drain(input string tag, input int max);
    int k = 0;
    while (pending() > 0 && k < max) begin
      tick();
      k++;
    end
    check_eq(tag, pending(), 0);
  endtask

  logic [1:0]  seq [6] = '{2'd0, 2'd1, 2'd0, 2'd2, 2'd0, 2'd3};
  logic [39:0] f;

  initial begin
    ready = 3'b111;
    upd();
    repeat (2) @(posedge clk);
    #1;
    check_eq("reset_outputs", {ctrl[0], ctrl[1], ctrl[2], pop, drop_err}, 0);
    rst_n = 1'b1;
    tick();
    check_eq("idle_outputs", {s_ctrl[0], s_ctrl[1], s_ctrl[2], s_pop, s_drop}, 0);

    // Single-flit x packet to (5,1): one cycle of allocation latency.
    f = hflit(4'd5, 4'd1, 1'b1, 30'h1111);
    push_in(0, f); push_exp(0, f);
    tick(); check_eq("t1_cycle0", s_ctrl[0], 0);
    tick(); check_eq("t1_ctrl", s_ctrl[0], 1); check_eq("t1_pop", s_pop[0], 1);
    tick(); check_eq("t1_after", s_ctrl[0], 0);
    drain("t1_drain", 10);

    // Four-flit local packet to (2,3) leaves on y.
    push_in(2, hflit(4'd2, 4'd3, 1'b0, 30'h2000)); push_exp(1, hflit(4'd2, 4'd3, 1'b0, 30'h2000));
    for (int k = 1; k < 4; k++) begin
      f = bflit(k == 3, 38'(k));
      push_in(2, f); push_exp(1, f);
    end
    tick(); check_eq("t2_cycle0", s_ctrl[1], 0);
    for (int k = 0; k < 4; k++) begin
      tick(); check_eq("t2_burst", s_ctrl[1], 3);
    end
    tick(); check_eq("t2_end", s_ctrl[1], 0);
    f = hflit(4'd2, 4'd3, 1'b1, 30'h2222);
    push_in(2, f); push_exp(1, f);
    tick(); check_eq("t2_relock_c0", s_ctrl[1], 0);
    tick(); check_eq("t2_relock", s_ctrl[1], 3);
    drain("t2_drain", 10);

    // Three inputs contend for local: round-robin x, y, local, then wrap to x.
    for (int p = 0; p < 3; p++) begin
      f = hflit(4'd2, 4'd1, 1'b1, 30'(32'h300 + p));
      push_in(p, f); push_exp(2, f);
    end
    for (int k = 0; k < 6; k++) begin
      tick(); check_eq("t3_order", s_ctrl[2], seq[k]);
    end
    f = hflit(4'd2, 4'd1, 1'b1, 30'h3010); push_in(0, f); push_exp(2, f);
    f = hflit(4'd2, 4'd1, 1'b1, 30'h3011); push_in(1, f); push_exp(2, f);
    tick(); tick(); check_eq("t3_wrap_x", s_ctrl[2], 1);
    tick(); tick(); check_eq("t3_wrap_y", s_ctrl[2], 2);
    drain("t3_drain", 10);

    // Backpressure on local mid-packet holds the grant without losing flits.
    push_in(0, hflit(4'd2, 4'd1, 1'b0, 30'h4000)); push_exp(2, hflit(4'd2, 4'd1, 1'b0, 30'h4000));
    for (int k = 1; k < 5; k++) begin
      f = bflit(k == 4, 38'(32'h400 + k));
      push_in(0, f); push_exp(2, f);
    end
    tick();
    tick(); check_eq("t4_flit1", s_ctrl[2], 1);
    tick(); check_eq("t4_flit2", s_ctrl[2], 1);
    ready[2] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick(); check_eq("t4_stall_ctrl", s_ctrl[2], 0); check_eq("t4_stall_pop", s_pop[0], 0);
    end
    ready[2] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick(); check_eq("t4_resume", s_ctrl[2], 1);
    end
    tick(); check_eq("t4_end", s_ctrl[2], 0);
    drain("t4_drain", 10);

    // Orphan body flit at y is discarded.
    f = bflit(1'b0, 38'h5555);
    push_in(1, f); dq.push_back({2'd1, f});
    tick();
    check_eq("t5_drop", s_drop, 1);
    check_eq("t5_pop", s_pop[1], 1);
    check_eq("t5_ctrl", {s_ctrl[0], s_ctrl[1], s_ctrl[2]}, 0);
    tick(); check_eq("t5_pulse", s_drop, 0);

    // Reset during flit 2 of 4: remaining flits become orphans.
    push_in(0, hflit(4'd5, 4'd1, 1'b0, 30'h6000)); push_exp(0, hflit(4'd5, 4'd1, 1'b0, 30'h6000));
    for (int k = 1; k < 4; k++) begin
      f = bflit(k == 3, 38'(32'h600 + k));
      push_in(0, f); dq.push_back({2'd0, f});
    end
    tick();
    tick(); check_eq("t6_head", s_ctrl[0], 1);
    rst_n = 1'b0;
    #1;
    check_eq("t6_rst_outputs", {ctrl[0], ctrl[1], ctrl[2], pop, drop_err}, 0);
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick(); check_eq("t6_orphan", s_drop, 1);
    end
    f = hflit(4'd2, 4'd0, 1'b1, 30'h6666);
    push_in(0, f); push_exp(1, f);
    tick(); check_eq("t6_new_c0", s_ctrl[1], 0);
    tick(); check_eq("t6_new_head", s_ctrl[1], 1);
    drain("t6_drain", 10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
